mem_1r1w_fifo_ctrl: RTL
=======================

# mem_1r1w_fifo_ctrl

Synchronous FIFO controller that drives one `mem_1r1w_masked_48x64` macro, a 48x64 array with one read port, one byte-masked write port and 1-cycle read latency. It turns a valid/ready enqueue stream into memory writes and prefetches memory reads into a 2-entry output staging buffer, giving a first-word-fall-through dequeue stream. It is the producer-side stage that feeds the macro's W0/R0 ports and consumes R0_data.

## Interface

Parameters:
- `DEPTH`, 48: memory entries; non-power-of-two allowed.
- `WIDTH`, 64: data width.
- `MASK_GRAN`, 8: bits per write-mask lane; mask width is WIDTH/MASK_GRAN.
- `ADDR_W`, 6: memory address width, ceil(log2(DEPTH)).

Ports:
- `clock`, in, 1: single clock. The parent ties the macro's R0_clk and W0_clk to it.
- `reset`, in, 1: synchronous, active-high.
- `enq_valid`, in, 1: enqueue request.
- `enq_ready`, out, 1: controller can accept.
- `enq_bits`, in, WIDTH: enqueue data.
- `deq_valid`, out, 1: staging head valid.
- `deq_ready`, in, 1: consumer accepts.
- `deq_bits`, out, WIDTH: staging head data.
- `count`, out, 6: total entries held (memory + in-flight read + staging), 0..DEPTH+2.
- `W0_addr`, out, ADDR_W: write address (tail pointer).
- `W0_en`, out, 1: write strobe.
- `W0_data`, out, WIDTH: equals enq_bits.
- `W0_mask`, out, WIDTH/MASK_GRAN: all ones when W0_en=1, else 0.
- `R0_addr`, out, ADDR_W: read address (head pointer).
- `R0_en`, out, 1: read strobe.
- `R0_data`, in, WIDTH: macro read data, valid the cycle after R0_en.

## Operation

State:
- `wptr` and `rptr`, each 0..DEPTH-1. Each wraps from DEPTH-1 to 0, never to 2^ADDR_W.
- `mem_cnt`, 0..DEPTH.
- `inflight`, 1 bit, read issued last cycle.
- `stg_cnt`, 0..2, with a 2-entry staging FIFO.

Handshake and flow control:
- enq_fire = enq_valid & enq_ready; deq_fire = deq_valid & deq_ready.
- enq_ready = !reset & (mem_cnt < DEPTH).
- deq_valid = stg_cnt != 0.
- deq_bits = staging head.

Enqueue routing:
- Bypass when enq_fire & mem_cnt==0 & !inflight & (stg_cnt - deq_fire) < 2. enq_bits is written directly into staging, with no memory write.
- Otherwise on enq_fire: W0_en=1 at wptr, then wptr advances.

Read issue:
- R0_en = (mem_cnt != 0) & (stg_cnt + inflight - deq_fire) < 2.
- When R0_en=1, rptr advances and inflight is set next cycle.

Read return:
- When inflight=1, R0_data is pushed into staging at the end of that cycle.
- In-flight plus staging never exceeds 2 by construction. No overflow is possible.

Counter updates:
- mem_cnt += W0_en − R0_en.
- stg_cnt += (bypass | inflight) − deq_fire.
- Bypass and read return never coincide, because bypass requires !inflight.

Ordering and invariants:
- Bypass is allowed only when memory and pipe are empty, so FIFO order is preserved.
- R0_addr == W0_addr with both enables high is impossible. Verification asserts this.
- Simultaneous enq and deq at any fill level are legal and leave count unchanged.
- At full (count = DEPTH+2), enq_ready=0. A deq that cycle re-enables enq_ready the next cycle only after the resulting read frees memory space. enq_ready depends on mem_cnt only.

## Timing

- Reset (synchronous): pointers, counters and inflight go to 0. While reset is asserted and in the first cycle after release: enq_ready=0 during reset, deq_valid=0, W0_en=R0_en=0, W0_mask=0, count=0. Staging data is don't-care.
- Reset asserted mid-operation discards all contents, including an in-flight read. The R0_data returned the cycle after reset is ignored.
- Bypass latency: enq_fire in cycle N gives deq_valid in N+1.
- Memory-path latency: write in N, R0_en no earlier than N+1, staging push at end of N+2, deq_valid in N+3.
- Throughput: 1 enq and 1 deq per cycle sustained, with no bubble under continuous deq_ready=1.
- count is registered and reflects all fires of the previous cycle.

## Test plan

- Reset: hold reset 3 cycles with enq_valid=1 → enq_ready=0, deq_valid=0, W0_en=R0_en=0, count=0. After release, enq_ready=1.
- Single bypass: enq 0xDEAD_BEEF at cycle N, deq_ready=1 → deq_valid=1 with deq_bits=0xDEAD_BEEF at N+1. W0_en never asserts.
- Fill to full: deq_ready=0, enq values 0..49 → first 2 bypass, 48 memory writes at W0_addr 0..47, then enq_ready=0 and count=50. Drain → 0..49 in order, with R0_addr 0..47.
- Wrap-around streaming: preload 30 entries, then 200 cycles of simultaneous enq/deq → W0_addr and R0_addr wrap 47→0. Output matches input order, count stays 30±1.
- Random backpressure: 10k cycles with enq_valid and deq_ready each at 50% → scoreboard order matches, count matches the model, read/write address collision assertion never fires.
- Reset mid-operation: 20 entries held with a read in flight, pulse reset 1 cycle → count=0, deq_valid=0. The next enq 0x1234 bypasses and appears at N+1.

Source files
------------

// File: rtl/mem_1r1w_fifo_ctrl.sv
// rtl/mem_1r1w_fifo_ctrl.sv - FIFO controller for a 1R1W byte-masked memory macro with a first-word-fall-through dequeue
//
// Turns a valid/ready enqueue stream into W0 writes. Reads are prefetched into a
// 2-entry staging buffer that drives the dequeue stream. When memory and the read pipe
// are both empty, an enqueue bypasses memory and goes straight into staging.
//
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   enq_valid/ready/bits enqueue stream
//   deq_valid/ready/bits dequeue stream (staging head)
//   count                entries held: memory + in-flight read + staging
//   W0_addr/en/data/mask macro write port (tail pointer)
//   R0_addr/en           macro read port (head pointer)
//   R0_data              macro read data, valid the cycle after R0_en
module mem_1r1w_fifo_ctrl #(
  parameter int DEPTH     = 48,
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8,
  parameter int ADDR_W    = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [WIDTH-1:0]           enq_bits,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [WIDTH-1:0]           deq_bits,
  output logic [5:0]                 count,
  output logic [ADDR_W-1:0]          W0_addr,
  output logic                       W0_en,
  output logic [WIDTH-1:0]           W0_data,
  output logic [WIDTH/MASK_GRAN-1:0] W0_mask,
  output logic [ADDR_W-1:0]          R0_addr,
  output logic                       R0_en,
  input  logic [WIDTH-1:0]           R0_data
);

  localparam int MASK_W = WIDTH / MASK_GRAN;
  localparam int MC_W   = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [MC_W-1:0]   mem_cnt_q, mem_cnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        stg_cnt_q, stg_cnt_d;
  logic              stg_head_q, stg_head_d;
  logic [5:0]        count_q, count_d;
  logic [WIDTH-1:0]  stg_data_q [2];
  logic [WIDTH-1:0]  stg_data_d [2];

  logic              enq_fire;
  logic              deq_fire;
  logic              bypass;
  logic              stg_push;
  logic              stg_tail;
  logic [2:0]        stg_after_deq;
  logic [2:0]        pipe_after_deq;
  logic [WIDTH-1:0]  stg_push_data;

  // Handshakes and memory-port strobes
  always_comb begin
    enq_ready = !reset && (mem_cnt_q < MC_W'(DEPTH));
    deq_valid = !reset && (stg_cnt_q != 2'd0);
    deq_bits  = stg_data_q[stg_head_q];
    enq_fire  = enq_valid && enq_ready;
    deq_fire  = deq_valid && deq_ready;

    // Staging occupancy after this cycle's pop, with and without the pending read
    stg_after_deq  = {1'b0, stg_cnt_q} - {2'b00, deq_fire};
    pipe_after_deq = {1'b0, stg_cnt_q} + {2'b00, inflight_q} - {2'b00, deq_fire};

    // Bypass only when nothing older exists anywhere, so ordering is kept
    bypass = enq_fire && (mem_cnt_q == '0) && !inflight_q && (stg_after_deq < 3'd2);

    W0_en   = enq_fire && !bypass;
    W0_addr = wptr_q;
    W0_data = enq_bits;
    W0_mask = {MASK_W{W0_en}};

    R0_en   = !reset && (mem_cnt_q != '0) && (pipe_after_deq < 3'd2);
    R0_addr = rptr_q;

    count = reset ? 6'd0 : count_q;
  end

  // Next-state logic
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_cnt_d  = mem_cnt_q + MC_W'(W0_en) - MC_W'(R0_en);
    inflight_d = R0_en;
    count_d    = count_q + 6'(enq_fire) - 6'(deq_fire);

    if (W0_en) begin
      wptr_d = (wptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wptr_q + ADDR_W'(1);
    end
    if (R0_en) begin
      rptr_d = (rptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rptr_q + ADDR_W'(1);
    end

    // Bypass and read return are mutually exclusive (bypass needs !inflight)
    stg_push      = bypass || inflight_q;
    stg_push_data = bypass ? enq_bits : R0_data;
    // A push into a full buffer only happens alongside a pop, in which case the
    // freed head slot is the tail slot as well
    stg_tail      = stg_head_q ^ stg_cnt_q[0];
    stg_head_d    = stg_head_q ^ deq_fire;
    stg_cnt_d     = stg_cnt_q + 2'(stg_push) - 2'(deq_fire);

    stg_data_d[0] = stg_data_q[0];
    stg_data_d[1] = stg_data_q[1];
    if (stg_push) begin
      stg_data_d[stg_tail] = stg_push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      stg_cnt_q  <= '0;
      stg_head_q <= 1'b0;
      count_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      stg_cnt_q  <= stg_cnt_d;
      stg_head_q <= stg_head_d;
      count_q    <= count_d;
    end
  end

  // Staging payload needs no reset; occupancy alone qualifies it
  always_ff @(posedge clock) begin
    stg_data_q[0] <= stg_data_d[0];
    stg_data_q[1] <= stg_data_d[1];
  end

endmodule
